stall_ctrl: RTL and testbench
=============================

STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 Parameter PC_WD, default 32: width of exception target PC.
REQ-002 Parameter CNT_WD, default 32: width of stall_cycles perf counter.
REQ-003 Parameter TIMEOUT_CYC, default 1023, legal range 1..65535: consecutive-stall watchdog threshold.
REQ-004 Ports, in order (name, direction, width, meaning):
- clk  in  1: clock; the block has one clock.
- resetn  in  1: reset, asynchronous, active-low.
- stallreq_if  in  1: fetch stage stall request.
- stallreq_id  in  1: decode stage stall request (forwarding load-use).
- stallreq_ex  in  1: execute stage stall request (mul/div busy).
- stallreq_mem  in  1: memory stage stall request (dcache busy).
- halt_req  in  1: debug halt; freezes the whole pipeline.
- excp_req  in  1: exception/redirect request from commit.
- excp_pc  in  PC_WD: redirect target, sampled with excp_req.
- stall  out  6: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold stage.
- flush  out  1: pipeline flush pulse, registered.
- flush_pc  out  PC_WD: redirect target, valid while flush=1.
- stall_timeout  out  1: sticky watchdog flag.
- stall_cycles  out  CNT_WD: count of cycles with stall[0]=1.

Function
REQ-005 Stall vector SHALL be combinational, the OR of per-request patterns: if 6'b000011, id 6'b000111, ex 6'b001111, mem 6'b011111, halt 6'b111111.
REQ-006 Every stall value SHALL be thermometer-shaped (stall[i]=1 implies stall[i-1]=1).
REQ-007 FSM states SHALL be RUN, FLUSH_WAIT, FLUSH; reset state RUN.
REQ-008 RUN, excp_req=1, stallreq_mem=0: capture excp_pc; next state FLUSH.
REQ-009 RUN, excp_req=1, stallreq_mem=1: capture excp_pc; next state FLUSH_WAIT.
REQ-010 FLUSH_WAIT: stall SHALL be at least 6'b011111 (OR with REQ-005 pattern); go to FLUSH in the first cycle stallreq_mem=0.
REQ-011 FLUSH: flush=1, flush_pc=captured PC, stall=6'b000000 regardless of requests including halt_req; next state RUN unconditionally.
REQ-012 flush SHALL be 1 only in FLUSH; latency excp_req (no mem stall) to flush = 1 cycle.
REQ-013 excp_req SHALL be ignored in FLUSH_WAIT and FLUSH; first captured PC wins, no queueing.
REQ-014 excp_req held high across FLUSH SHALL be re-accepted in the following RUN cycle (one new flush per request acceptance).
REQ-015 flush_pc SHALL hold its last captured value outside FLUSH.
REQ-016 stall_cycles SHALL increment by 1 each cycle stall[0]=1, saturating at all-ones.
REQ-017 Internal 16-bit run_len SHALL increment each cycle stall!=0, clear to 0 when stall==0, saturate at 65535.
REQ-018 stall_timeout SHALL set in the cycle after run_len reaches TIMEOUT_CYC and stay 1 until reset.
REQ-019 Simultaneous halt_req and excp_req in RUN without mem stall: flush wins per REQ-011; halt resumes in the following RUN cycle.

Reset
REQ-020 resetn=0 SHALL immediately force: state RUN, flush=0, flush_pc=0, stall_timeout=0, stall_cycles=0, run_len=0; stall then follows REQ-005 combinationally.
REQ-021 Reset asserted in FLUSH_WAIT or FLUSH SHALL discard the pending flush; no flush pulse after release.
REQ-022 Stall requests SHALL be honoured in the first cycle after reset release.

Verification
REQ-023 stallreq_id=1 only -> stall=6'b000111, flush=0; stallreq_id+stallreq_mem -> 6'b011111.
REQ-024 excp_req=1, excp_pc=0x1C000100 at cycle N, mem idle -> flush=1, flush_pc=0x1C000100, stall=0 at N+1; flush=0 at N+2.
REQ-025 stallreq_mem=1 cycles N..N+3, excp_req pulse at N (pc 0x80), second excp_req at N+2 (pc 0x90) -> stall=6'b011111 N+1..N+3, single flush at N+5 with flush_pc=0x80.
REQ-026 TIMEOUT_CYC=4, stallreq_ex held 4 cycles -> stall_timeout=1 on the 5th cycle, remains 1 after stall drops; stall_cycles=4.
REQ-027 resetn low in FLUSH_WAIT -> outputs zero asynchronously; after release no flush occurs.
REQ-028 halt_req and excp_req same cycle, mem idle -> next cycle flush=1, stall=0; following cycle stall=6'b111111.

Source files
------------

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: merges per-stage stall requests into a
// thermometer hold vector and sequences exception redirects into one flush pulse.
module stall_ctrl #(
   parameter int PC_WD       = 32,
   parameter int CNT_WD      = 32,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              stallreq_if,
   input  logic              stallreq_id,
   input  logic              stallreq_ex,
   input  logic              stallreq_mem,
   input  logic              halt_req,
   input  logic              excp_req,
   input  logic [PC_WD-1:0]  excp_pc,
   output logic [5:0]        stall,
   output logic              flush,
   output logic [PC_WD-1:0]  flush_pc,
   output logic              stall_timeout,
   output logic [CNT_WD-1:0] stall_cycles
);

   localparam logic [1:0] ST_RUN        = 2'd0;
   localparam logic [1:0] ST_FLUSH_WAIT = 2'd1;
   localparam logic [1:0] ST_FLUSH      = 2'd2;

   // Setting the flag on the edge where run_len becomes TIMEOUT_CYC makes it
   // visible in the cycle right after the threshold run completes.
   localparam logic [15:0] RUN_LEN_LAST = 16'(TIMEOUT_CYC - 1);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [5:0]       req_pat;
   logic             excp_acc;
   logic [PC_WD-1:0] pc_q;
   logic             flush_q;
   logic [15:0]      run_len;

   always_comb begin
      req_pat = 6'b000000;
      if (stallreq_if)  req_pat = req_pat | 6'b000011;
      if (stallreq_id)  req_pat = req_pat | 6'b000111;
      if (stallreq_ex)  req_pat = req_pat | 6'b001111;
      if (stallreq_mem) req_pat = req_pat | 6'b011111;
      if (halt_req)     req_pat = req_pat | 6'b111111;
   end

   // The flush cycle releases every stage so the redirect can propagate;
   // while waiting on the dcache, everything up to MEM is held.
   always_comb begin
      case (state)
         ST_FLUSH:      stall = 6'b000000;
         ST_FLUSH_WAIT: stall = req_pat | 6'b011111;
         default:       stall = req_pat;
      endcase
   end

   // excp_req acts as a valid with an implicit ready of (state == RUN): an
   // accepted request captures excp_pc and owes exactly one flush pulse;
   // requests seen outside RUN are dropped, never queued.
   assign excp_acc = (state == ST_RUN) && excp_req;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN: begin
            if (excp_acc) state_nxt = stallreq_mem ? ST_FLUSH_WAIT : ST_FLUSH;
         end
         ST_FLUSH_WAIT: begin
            if (!stallreq_mem) state_nxt = ST_FLUSH;
         end
         ST_FLUSH: state_nxt = ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= ST_RUN;
         flush_q <= 1'b0;
         pc_q    <= '0;
      end else begin
         state   <= state_nxt;
         flush_q <= (state_nxt == ST_FLUSH);
         if (excp_acc) pc_q <= excp_pc;
      end
   end

   assign flush    = flush_q;
   assign flush_pc = pc_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_cycles  <= '0;
         run_len       <= 16'd0;
         stall_timeout <= 1'b0;
      end else begin
         if (stall[0] && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_WD'(1);
         if (stall == 6'b000000)
            run_len <= 16'd0;
         else if (run_len != 16'hFFFF)
            run_len <= run_len + 16'd1;
         if ((stall != 6'b000000) && (run_len >= RUN_LEN_LAST))
            stall_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: the driver pushes per-cycle expectations,
// a negedge monitor pops and compares them, and flush PCs use their own queue.
module tb_stall_ctrl;

   localparam int EW = 58;
   localparam logic [5:0] R_NONE = 6'b000000;
   localparam logic [5:0] R_IF   = 6'b000001;
   localparam logic [5:0] R_ID   = 6'b000010;
   localparam logic [5:0] R_EX   = 6'b000100;
   localparam logic [5:0] R_MEM  = 6'b001000;
   localparam logic [5:0] R_HALT = 6'b010000;
   localparam logic [5:0] R_EXC  = 6'b100000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
   logic        halt_req, excp_req;
   logic [31:0] excp_pc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] flush_pc;
   logic        stall_timeout;
   logic [31:0] stall_cycles;

   logic [EW-1:0] exp_q[$];
   logic [31:0]   flush_q[$];
   logic [EW-1:0] mon_e;
   int checks   = 0;
   int failures = 0;
   int step_no  = 0;

   stall_ctrl #(.PC_WD(32), .CNT_WD(32), .TIMEOUT_CYC(4)) dut (
      .clk(clk), .resetn(resetn),
      .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
      .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
      .halt_req(halt_req), .excp_req(excp_req), .excp_pc(excp_pc),
      .stall(stall), .flush(flush), .flush_pc(flush_pc),
      .stall_timeout(stall_timeout), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d actual=0x%0h expected=0x%0h", name, tag, act, exp);
      end
   endtask

   task automatic set_in(input logic [5:0] r, input logic [31:0] pc);
      stallreq_if  = r[0];
      stallreq_id  = r[1];
      stallreq_ex  = r[2];
      stallreq_mem = r[3];
      halt_req     = r[4];
      excp_req     = r[5];
      excp_pc      = pc;
   endtask

   // Drive one cycle's inputs and record what the DUT must show in that cycle.
   task automatic step(input logic [5:0] r, input logic [31:0] pc,
                       input logic [5:0] es, input logic ef,
                       input logic cto, input logic eto,
                       input logic ccnt, input logic [31:0] ecnt);
      @(posedge clk);
      #1;
      set_in(r, pc);
      step_no++;
      exp_q.push_back({16'(step_no), cto, ccnt, es, ef, eto, ecnt});
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      resetn = 1'b0;
      set_in(R_NONE, 32'h0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   always @(negedge clk) begin
      if (resetn === 1'b1 && exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("stall", int'(mon_e[57:42]), {26'b0, stall}, {26'b0, mon_e[39:34]});
         chk("flush", int'(mon_e[57:42]), {31'b0, flush}, {31'b0, mon_e[33]});
         if (mon_e[41])
            chk("stall_timeout", int'(mon_e[57:42]), {31'b0, stall_timeout}, {31'b0, mon_e[32]});
         if (mon_e[40])
            chk("stall_cycles", int'(mon_e[57:42]), stall_cycles, mon_e[31:0]);
      end
      if (resetn === 1'b1 && flush === 1'b1) begin
         if (flush_q.size() == 0)
            chk("flush_unexpected", step_no, {31'b0, flush}, 32'd0);
         else
            chk("flush_pc", step_no, flush_pc, flush_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0;
      set_in(R_NONE, 32'h0);
      #3;
      chk("rst_stall", 0, {26'b0, stall}, 32'd0);
      chk("rst_flush", 0, {31'b0, flush}, 32'd0);
      chk("rst_flush_pc", 0, flush_pc, 32'd0);
      chk("rst_timeout", 0, {31'b0, stall_timeout}, 32'd0);
      chk("rst_cycles", 0, stall_cycles, 32'd0);
      stallreq_ex = 1'b1;
      #1;
      chk("rst_stall_comb", 0, {26'b0, stall}, 32'h0F);
      stallreq_ex = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;

      // Request patterns, perf counter and watchdog over a 5-cycle stall run
      step(R_ID,         32'h0, 6'b000111, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
      step(R_ID | R_MEM, 32'h0, 6'b011111, 1'b0, 1'b1, 1'b0, 1'b1, 32'd1);
      step(R_IF,         32'h0, 6'b000011, 1'b0, 1'b1, 1'b0, 1'b1, 32'd2);
      step(R_EX,         32'h0, 6'b001111, 1'b0, 1'b1, 1'b0, 1'b1, 32'd3);
      step(R_HALT,       32'h0, 6'b111111, 1'b0, 1'b1, 1'b1, 1'b1, 32'd4);
      step(R_NONE,       32'h0, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b1, 32'd5);
      do_reset();

      // Exception with memory idle: flush one cycle later
      flush_q.push_back(32'h1C000100);
      step(R_EXC,  32'h1C000100, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
      step(R_NONE, 32'h0,        6'b000000, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0);
      step(R_NONE, 32'h0,        6'b000000, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);

      // Exception under dcache stall; second request during wait is dropped
      flush_q.push_back(32'h80);
      step(R_MEM | R_EXC, 32'h80, 6'b011111, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
      step(R_MEM,         32'h0,  6'b011111, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step(R_MEM | R_EXC, 32'h90, 6'b011111, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step(R_MEM,         32'h0,  6'b011111, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step(R_NONE,        32'h0,  6'b011111, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step(R_NONE,        32'h0,  6'b000000, 1'b1, 1'b0, 1'b0, 1'b1, 32'd5);
      step(R_NONE,        32'h0,  6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5);
      do_reset();

      // Halt and exception together: flush wins, halt resumes afterwards
      flush_q.push_back(32'h1234);
      step(R_HALT | R_EXC, 32'h1234, 6'b111111, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step(R_HALT,         32'h0,    6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      step(R_HALT,         32'h0,    6'b111111, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step(R_NONE,         32'h0,    6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

      // excp_req held high across FLUSH is accepted again in the next RUN cycle
      flush_q.push_back(32'h40);
      flush_q.push_back(32'h48);
      step(R_EXC,  32'h40, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step(R_EXC,  32'h44, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      step(R_EXC,  32'h48, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step(R_NONE, 32'h0,  6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      step(R_NONE, 32'h0,  6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("flush_pc_hold", step_no, flush_pc, 32'h48);
      do_reset();

      // Watchdog threshold of 4 with an execute stall held 4 cycles
      step(R_EX,   32'h0, 6'b001111, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
      step(R_EX,   32'h0, 6'b001111, 1'b0, 1'b1, 1'b0, 1'b1, 32'd1);
      step(R_EX,   32'h0, 6'b001111, 1'b0, 1'b1, 1'b0, 1'b1, 32'd2);
      step(R_EX,   32'h0, 6'b001111, 1'b0, 1'b1, 1'b0, 1'b1, 32'd3);
      step(R_NONE, 32'h0, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b1, 32'd4);
      step(R_NONE, 32'h0, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b1, 32'd4);
      do_reset();

      // Reset asserted while waiting to flush discards the pending redirect
      step(R_MEM | R_EXC, 32'hAA, 6'b011111, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
      step(R_MEM,         32'h0,  6'b011111, 1'b0, 1'b1, 1'b0, 1'b1, 32'd1);
      @(negedge clk);
      #1;
      set_in(R_NONE, 32'h0);
      resetn = 1'b0;
      #1;
      chk("async_rst_stall", step_no, {26'b0, stall}, 32'd0);
      chk("async_rst_flush", step_no, {31'b0, flush}, 32'd0);
      chk("async_rst_flush_pc", step_no, flush_pc, 32'd0);
      chk("async_rst_timeout", step_no, {31'b0, stall_timeout}, 32'd0);
      chk("async_rst_cycles", step_no, stall_cycles, 32'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      step(R_NONE, 32'h0, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
      step(R_NONE, 32'h0, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
      step(R_NONE, 32'h0, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);

      @(negedge clk);
      #1;
      chk("exp_q_drained", step_no, 32'(exp_q.size()), 32'd0);
      chk("flush_q_drained", step_no, 32'(flush_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
